// File: rtl/kbdmk1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : kbdmk1_pkg                                                   |
// | Description : MK1 keyboard link constants and types shared by both ends.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package kbdmk1_pkg;

    localparam int MK1_FRAME_BITS  = 128;
    localparam int MK1_MATRIX_BITS = 80;
    localparam int MK1_LED_BITS    = 96;
    localparam int MK1_IDLE_CYCLES = 64;
    localparam int MK1_LED_W       = 24;

    // led1 is received first, so it lands in the most significant word
    localparam int MK1_LED1_LSB = MK1_LED_BITS - 1 * MK1_LED_W;
    localparam int MK1_LED2_LSB = MK1_LED_BITS - 2 * MK1_LED_W;
    localparam int MK1_LED3_LSB = MK1_LED_BITS - 3 * MK1_LED_W;
    localparam int MK1_LED4_LSB = MK1_LED_BITS - 4 * MK1_LED_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_COMMIT = 2'd2
    } kbdmk1_state_e;

    function automatic int mk1_led_lsb(input int led_bits, input int idx);
        return led_bits - (idx + 1) * MK1_LED_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbdmk1_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : kbdmk1_responder_if                                          |
// | Description : MK1 serial link wires; host is master, keyboard is slave.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface kbdmk1_responder_if;

    logic kb_ck;
    logic kb_do;
    logic kb_di;

    modport master (output kb_ck, output kb_do, input  kb_di);
    modport slave  (input  kb_ck, input  kb_do, output kb_di);

endinterface
`default_nettype wire

// File: rtl/kbdmk1_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kbdmk1_edge_sync                                             |
// | Description : kb_ck/kb_do synchronizers, edge strobes and idle-gap counter.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module kbdmk1_edge_sync
    import kbdmk1_pkg::*;
#(
    parameter int IDLE_CYCLES = MK1_IDLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ck,
    input  logic i_do,
    output logic o_rise,
    output logic o_fall,
    output logic o_do,
    output logic o_gap
);

    localparam int              c_GW      = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_GW-1:0] c_GAP_MAX = c_GW'(IDLE_CYCLES);

    logic [2:0]      r_ck_pipe;
    logic [2:0]      r_do_pipe;
    logic            r_rise;
    logic            r_fall;
    logic [c_GW-1:0] r_gap_cnt;

    // The gap counter runs off the last pipe stage so that it still reads
    // saturated in the cycle the registered fall strobe is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ck_pipe <= 3'b111;
            r_do_pipe <= 3'b000;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_ck_pipe <= {r_ck_pipe[1:0], i_ck};
            r_do_pipe <= {r_do_pipe[1:0], i_do};
            r_rise    <= r_ck_pipe[1] & ~r_ck_pipe[2];
            r_fall    <= ~r_ck_pipe[1] & r_ck_pipe[2];
            if (!r_ck_pipe[2]) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != c_GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_do   = r_do_pipe[2];
    assign o_gap  = (r_gap_cnt == c_GAP_MAX);

endmodule
`default_nettype wire

// File: rtl/kbdmk1_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : kbdmk1_responder                                             |
// | Description : Keyboard end of the MK1 link: key-matrix TX, RGB LED RX.     |
// |               KBDMK1_RESPONDER_STATS_EN adds frame/error counters.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module kbdmk1_responder
    import kbdmk1_pkg::*;
#(
    parameter int FRAME_BITS  = MK1_FRAME_BITS,
    parameter int MATRIX_BITS = MK1_MATRIX_BITS,
    parameter int LED_BITS    = MK1_LED_BITS,
    parameter int IDLE_CYCLES = MK1_IDLE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    kbdmk1_responder_if.slave    kb,
    input  logic [6:0]           kbd_scancode,
    input  logic                 kbd_keypress,
    input  logic                 kbd_strobe,
    output logic [MK1_LED_W-1:0] led1_rgb,
    output logic [MK1_LED_W-1:0] led2_rgb,
    output logic [MK1_LED_W-1:0] led3_rgb,
    output logic [MK1_LED_W-1:0] led4_rgb,
    output logic                 frame_done,
    output logic                 frame_error
`ifdef KBDMK1_RESPONDER_STATS_EN
    ,
    output logic [15:0]          frame_count,
    output logic [15:0]          error_count
`endif
);

    localparam int              c_BW       = $clog2(FRAME_BITS + 1);
    localparam logic [c_BW-1:0] c_LED_LIM  = c_BW'(LED_BITS);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(FRAME_BITS - 1);
    localparam logic [6:0]      c_KEY_LIM  = 7'(MATRIX_BITS);
    localparam int              c_L1       = mk1_led_lsb(LED_BITS, 0);
    localparam int              c_L2       = mk1_led_lsb(LED_BITS, 1);
    localparam int              c_L3       = mk1_led_lsb(LED_BITS, 2);
    localparam int              c_L4       = mk1_led_lsb(LED_BITS, 3);

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_do;
    logic                   w_gap;

    kbdmk1_state_e          r_state;
    logic [c_BW-1:0]        r_bit_cnt;
    logic [MATRIX_BITS-1:0] r_matrix;
    logic [MATRIX_BITS-1:0] r_tx;
    logic [LED_BITS-1:0]    r_led_sr;
    logic [MK1_LED_W-1:0]   r_led1, r_led2, r_led3, r_led4;
    logic                   r_frame_done;
    logic                   r_frame_error;

    kbdmk1_edge_sync #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (reset),
        .i_ck   (kb.kb_ck),
        .i_do   (kb.kb_do),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_do   (w_do),
        .o_gap  (w_gap)
    );

    // kb_di is always r_tx[0]; shifting in 1s covers the tail past the matrix
    // and an all-ones r_tx is the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_matrix      <= '1;
            r_tx          <= '1;
            r_led_sr      <= '0;
            r_led1        <= '0;
            r_led2        <= '0;
            r_led3        <= '0;
            r_led4        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            if (kbd_strobe && (kbd_scancode < c_KEY_LIM)) begin
                r_matrix[kbd_scancode] <= ~kbd_keypress;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && w_gap) begin
                        r_state   <= ST_FRAME;
                        r_tx      <= r_matrix;
                        r_bit_cnt <= '0;
                    end
                end
                ST_FRAME: begin
                    if (w_gap) begin
                        r_frame_error <= 1'b1;
                        r_tx          <= '1;
                        r_state       <= ST_IDLE;
                    end else if (w_fall) begin
                        r_tx <= {1'b1, r_tx[MATRIX_BITS-1:1]};
                    end else if (w_rise) begin
                        if (r_bit_cnt < c_LED_LIM) begin
                            r_led_sr <= {r_led_sr[LED_BITS-2:0], w_do};
                        end
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_led1       <= r_led_sr[c_L1 +: MK1_LED_W];
                    r_led2       <= r_led_sr[c_L2 +: MK1_LED_W];
                    r_led3       <= r_led_sr[c_L3 +: MK1_LED_W];
                    r_led4       <= r_led_sr[c_L4 +: MK1_LED_W];
                    r_frame_done <= 1'b1;
                    r_tx         <= '1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_tx    <= '1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign kb.kb_di    = r_tx[0];
    assign led1_rgb    = r_led1;
    assign led2_rgb    = r_led2;
    assign led3_rgb    = r_led3;
    assign led4_rgb    = r_led4;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;

`ifdef KBDMK1_RESPONDER_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_error_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
            r_error_count <= '0;
        end else begin
            if (r_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (r_frame_error) begin
                r_error_count <= r_error_count + 16'd1;
            end
        end
    end

    assign frame_count = r_frame_count;
    assign error_count = r_error_count;
`endif

endmodule
`default_nettype wire
